// File: rtl/uart.sv
// uart: 8N1 serial port, 16x oversampled, with a small FIFO per direction.
// Bus strobes arrive asynchronously and are synchronised before use.
module uart #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       cs,
  input  logic [2:0] a,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts,
  input  logic       dcd,
  input  logic       dsr,
  input  logic       ri,
  output logic       rts,
  output logic       dtr,
  output logic       tx_irq,
  output logic       rx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [2:0]           r_wrSync, r_rdSync;
  logic                 r_rdIsData;
  logic [3:0]           r_modemS1, r_modemS2;
  logic [1:0]           r_rxdS;
  logic [3:0]           r_ctrl;
  logic [DIV_WIDTH-1:0] r_divisor, r_baudCnt;
  logic                 r_overrun, r_framing, r_txIrq, r_rxIrq;

  logic [7:0]    r_txMem [FIFO_DEPTH];
  logic [AW-1:0] r_txWp, r_txRp;
  logic [AW:0]   r_txCnt;
  logic [1:0]    r_txState;
  logic [3:0]    r_txTickCnt;
  logic [2:0]    r_txBitCnt;
  logic [7:0]    r_txShift;
  logic          r_txd;

  logic [7:0]    r_rxMem [FIFO_DEPTH];
  logic [AW-1:0] r_rxWp, r_rxRp;
  logic [AW:0]   r_rxCnt;
  logic [1:0]    r_rxState;
  logic [3:0]    r_rxTickCnt;
  logic [2:0]    r_rxBitCnt;
  logic [7:0]    r_rxShift;

  logic        w_wrCommit, w_rdRise, w_rdFall, w_tick, w_rxd, w_cts;
  logic        w_dataWrite, w_statusWrite, w_ctrlWrite, w_divLoWrite, w_divHiWrite;
  logic        w_txEmpty, w_txFull, w_txPush, w_txStart, w_txIdle;
  logic        w_rxEmpty, w_rxFull, w_rxPop, w_rxDone, w_rxPush, w_rxWrite, w_rxFrameErr;
  logic [15:0] w_div16;

  assign w_wrCommit    = r_wrSync[1] & ~r_wrSync[2];
  assign w_rdRise      = r_rdSync[1] & ~r_rdSync[2];
  assign w_rdFall      = ~r_rdSync[1] & r_rdSync[2];
  assign w_dataWrite   = w_wrCommit && (a == 3'd0);
  assign w_statusWrite = w_wrCommit && (a == 3'd1);
  assign w_ctrlWrite   = w_wrCommit && (a == 3'd2);
  assign w_divLoWrite  = w_wrCommit && (a == 3'd3);
  assign w_divHiWrite  = w_wrCommit && (a == 3'd4);
  assign w_rxd         = r_rxdS[1];
  assign w_cts         = r_modemS2[0];
  assign w_div16       = 16'(r_divisor);
  assign w_tick        = (r_baudCnt == r_divisor);

  // The data-register flag is captured at the read's start so the pop on the
  // trailing edge does not depend on A still being valid then.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_wrSync   <= '0;
      r_rdSync   <= '0;
      r_rdIsData <= 1'b0;
      r_modemS1  <= '0;
      r_modemS2  <= '0;
      r_rxdS     <= 2'b11;
    end else begin
      r_wrSync  <= {r_wrSync[1:0], cs & wr};
      r_rdSync  <= {r_rdSync[1:0], cs & rd};
      if (w_rdRise) r_rdIsData <= (a == 3'd0);
      r_modemS1 <= {ri, dsr, dcd, cts};
      r_modemS2 <= r_modemS1;
      r_rxdS    <= {r_rxdS[0], rxd};
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ctrl    <= '0;
      r_divisor <= '0;
      r_baudCnt <= '0;
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
      r_txIrq   <= 1'b0;
      r_rxIrq   <= 1'b0;
    end else begin
      if (w_ctrlWrite)  r_ctrl    <= din[3:0];
      if (w_divLoWrite) r_divisor <= DIV_WIDTH'({w_div16[15:8], din});
      if (w_divHiWrite) r_divisor <= DIV_WIDTH'({din, w_div16[7:0]});
      if (w_divLoWrite || w_divHiWrite || w_tick) r_baudCnt <= '0;
      else                                        r_baudCnt <= r_baudCnt + 1'b1;
      if (w_statusWrite) begin
        r_overrun <= 1'b0;
        r_framing <= 1'b0;
      end
      if (w_rxPush && w_rxFull && !w_rxPop) r_overrun <= 1'b1;
      if (w_rxFrameErr)                     r_framing <= 1'b1;
      r_rxIrq <= r_ctrl[0] & (~w_rxEmpty | r_overrun | r_framing);
      r_txIrq <= r_ctrl[1] & w_txEmpty;
    end
  end

  assign w_txEmpty = (r_txCnt == '0);
  assign w_txFull  = (r_txCnt == FULL_CNT);
  assign w_txPush  = w_dataWrite & ~w_txFull;
  assign w_txIdle  = w_txEmpty & (r_txState == S_IDLE);
  assign w_txStart = w_tick & ~w_txEmpty & w_cts &
                     ((r_txState == S_IDLE) || ((r_txState == S_STOP) && (r_txTickCnt == 4'd15)));

  always_ff @(posedge clk) begin
    if (w_txPush) r_txMem[r_txWp] <= din;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_txWp  <= '0;
      r_txRp  <= '0;
      r_txCnt <= '0;
    end else begin
      if (w_txPush)  r_txWp <= r_txWp + 1'b1;
      if (w_txStart) r_txRp <= r_txRp + 1'b1;
      if (w_txPush && !w_txStart)      r_txCnt <= r_txCnt + 1'b1;
      else if (!w_txPush && w_txStart) r_txCnt <= r_txCnt - 1'b1;
    end
  end

  // A new character may start straight out of the final stop tick, so
  // back-to-back characters carry no idle gap.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_txState   <= S_IDLE;
      r_txTickCnt <= '0;
      r_txBitCnt  <= '0;
      r_txShift   <= '0;
      r_txd       <= 1'b1;
    end else if (w_txStart) begin
      r_txState   <= S_START;
      r_txTickCnt <= '0;
      r_txShift   <= r_txMem[r_txRp];
      r_txd       <= 1'b0;
    end else if (w_tick) begin
      case (r_txState)
        S_START: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) begin
            r_txState  <= S_DATA;
            r_txBitCnt <= '0;
            r_txd      <= r_txShift[0];
          end
        end
        S_DATA: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) begin
            if (r_txBitCnt == 3'd7) begin
              r_txState <= S_STOP;
              r_txd     <= 1'b1;
            end else begin
              r_txBitCnt <= r_txBitCnt + 1'b1;
              r_txShift  <= {1'b0, r_txShift[7:1]};
              r_txd      <= r_txShift[1];
            end
          end
        end
        S_STOP: begin
          r_txTickCnt <= r_txTickCnt + 1'b1;
          if (r_txTickCnt == 4'd15) r_txState <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign w_rxEmpty    = (r_rxCnt == '0);
  assign w_rxFull     = (r_rxCnt == FULL_CNT);
  assign w_rxPop      = w_rdFall & r_rdIsData & ~w_rxEmpty;
  assign w_rxDone     = w_tick && (r_rxState == S_STOP) && (r_rxTickCnt == 4'd15);
  assign w_rxPush     = w_rxDone & w_rxd;
  assign w_rxFrameErr = w_rxDone & ~w_rxd;
  assign w_rxWrite    = w_rxPush & (~w_rxFull | w_rxPop);

  always_ff @(posedge clk) begin
    if (w_rxWrite) r_rxMem[r_rxWp] <= r_rxShift;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_rxWp  <= '0;
      r_rxRp  <= '0;
      r_rxCnt <= '0;
    end else begin
      if (w_rxWrite) r_rxWp <= r_rxWp + 1'b1;
      if (w_rxPop)   r_rxRp <= r_rxRp + 1'b1;
      if (w_rxWrite && !w_rxPop)      r_rxCnt <= r_rxCnt + 1'b1;
      else if (!w_rxWrite && w_rxPop) r_rxCnt <= r_rxCnt - 1'b1;
    end
  end

  // The line must still be low at the eighth tick; that point then becomes
  // the mid-bit reference for every later 16-tick sample.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_rxState   <= S_IDLE;
      r_rxTickCnt <= '0;
      r_rxBitCnt  <= '0;
      r_rxShift   <= '0;
    end else if (w_tick) begin
      case (r_rxState)
        S_IDLE: begin
          if (!w_rxd) begin
            r_rxState   <= S_START;
            r_rxTickCnt <= '0;
          end
        end
        S_START: begin
          r_rxTickCnt <= r_rxTickCnt + 1'b1;
          if (r_rxTickCnt == 4'd7) begin
            if (w_rxd) begin
              r_rxState <= S_IDLE;
            end else begin
              r_rxState   <= S_DATA;
              r_rxTickCnt <= '0;
              r_rxBitCnt  <= '0;
            end
          end
        end
        S_DATA: begin
          r_rxTickCnt <= r_rxTickCnt + 1'b1;
          if (r_rxTickCnt == 4'd15) begin
            r_rxShift  <= {w_rxd, r_rxShift[7:1]};
            r_rxBitCnt <= r_rxBitCnt + 1'b1;
            if (r_rxBitCnt == 3'd7) r_rxState <= S_STOP;
          end
        end
        S_STOP: begin
          r_rxTickCnt <= r_rxTickCnt + 1'b1;
          if (r_rxTickCnt == 4'd15) r_rxState <= S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    case (a)
      3'd0: if (!w_rxEmpty) dout = r_rxMem[r_rxRp];
      3'd1: dout = {3'b000, r_framing, w_txIdle, r_overrun, ~w_txFull, ~w_rxEmpty};
      3'd2: dout = {4'h0, r_ctrl};
      3'd3: dout = w_div16[7:0];
      3'd4: dout = w_div16[15:8];
      3'd5: dout = {4'h0, r_modemS2};
      default: dout = 8'h00;
    endcase
  end

  assign txd    = r_txd;
  assign rts    = r_ctrl[2];
  assign dtr    = r_ctrl[3];
  assign tx_irq = r_txIrq;
  assign rx_irq = r_rxIrq;
endmodule

// File: tb/tb_uart.sv
// tb_uart: directed scenario tests for the uart serial port, each task
// checking its own expected values against hand-computed constants.
`timescale 1ns/1ps
module tb_uart;
  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0] a = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       rxdDrv = 1'b1, loopEn = 1'b0, rxdW;
  logic       txd;
  logic       cts = 1'b1, dcd = 1'b0, dsr = 1'b1, ri = 1'b0;
  logic       rts, dtr, tx_irq, rx_irq;
  int         checks = 0;
  int         failures = 0;

  assign rxdW = loopEn ? txd : rxdDrv;

  always #5 clk = ~clk;

  uart #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk(clk), .nRST(nRST), .cs(cs), .a(a), .rd(rd), .wr(wr), .din(din),
    .dout(dout), .rxd(rxdW), .txd(txd), .cts(cts), .dcd(dcd), .dsr(dsr),
    .ri(ri), .rts(rts), .dtr(dtr), .tx_irq(tx_irq), .rx_irq(rx_irq)
  );

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    a = addr; din = data; cs = 1'b1; wr = 1'b1;
    waitCycles(4);
    wr = 1'b0; cs = 1'b0;
    waitCycles(4);
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [7:0] data);
    @(posedge clk); #1;
    a = addr; cs = 1'b1; rd = 1'b1;
    waitCycles(4);
    data = dout;
    rd = 1'b0; cs = 1'b0;
    waitCycles(5);
  endtask

  task automatic setDivisor(input logic [15:0] v);
    busWrite(3'd3, v[7:0]);
    busWrite(3'd4, v[15:8]);
  endtask

  task automatic sendSerial(input logic [7:0] b, input logic stopBit);
    rxdDrv = 1'b0;
    waitCycles(16);
    for (int i = 0; i < 8; i++) begin
      rxdDrv = b[i];
      waitCycles(16);
    end
    rxdDrv = stopBit;
    waitCycles(16);
    rxdDrv = 1'b1;
    waitCycles(16);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic [7:0] expRegs [8];
    expRegs = '{8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
    nRST = 1'b0;
    waitCycles(3);
    checks++;
    if ({txd, rts, dtr, tx_irq, rx_irq} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_pins: got txd/rts/dtr/txirq/rxirq=%b expected 10000", {txd, rts, dtr, tx_irq, rx_irq});
    end
    nRST = 1'b1;
    waitCycles(3);
    for (int r = 0; r < 8; r++) begin
      busRead(3'(r), d);
      checks++;
      if (d !== expRegs[r]) begin
        failures++;
        $display("[TB] FAIL reset_reg%0d: got %h expected %h", r, d, expRegs[r]);
      end
    end
  endtask

  task automatic test_control();
    logic [7:0] d;
    busWrite(3'd2, 8'hFE);
    busRead(3'd2, d);
    checks++;
    if (d !== 8'h0E) begin
      failures++;
      $display("[TB] FAIL ctrl_read: got %h expected 0e", d);
    end
    checks++;
    if ({rts, dtr, tx_irq, rx_irq} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL ctrl_pins: got rts/dtr/txirq/rxirq=%b expected 1110", {rts, dtr, tx_irq, rx_irq});
    end
    busWrite(3'd2, 8'h00);
    checks++;
    if ({rts, dtr, tx_irq} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL ctrl_clear: got rts/dtr/txirq=%b expected 000", {rts, dtr, tx_irq});
    end
  endtask

  task automatic test_tx_waveform();
    logic [7:0] d;
    logic [8:0] expBits;
    logic       fell;
    int         lowCnt;
    expBits = {1'b1, 8'h55};
    setDivisor(16'h0001);
    cts = 1'b0;
    waitCycles(4);
    busWrite(3'd0, 8'h55);
    cts = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 60; i++) begin
      waitCycles(1);
      if (txd == 1'b0) begin
        fell = 1'b1;
        break;
      end
    end
    checks++;
    if (!fell) begin
      failures++;
      $display("[TB] FAIL tx_start_fall: got no start bit expected txd low within 60 clk");
    end
    lowCnt = 1;
    for (int i = 0; i < 100; i++) begin
      waitCycles(1);
      if (txd != 1'b0) break;
      lowCnt++;
    end
    checks++;
    if (lowCnt != 32) begin
      failures++;
      $display("[TB] FAIL tx_start_len: got %0d clk expected 32", lowCnt);
    end
    waitCycles(15);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (txd !== expBits[i]) begin
        failures++;
        $display("[TB] FAIL tx_bit%0d: got %b expected %b", i, txd, expBits[i]);
      end
      waitCycles(32);
    end
    waitCycles(20);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL tx_idle_status: got %h expected 0a", d);
    end
  endtask

  task automatic test_loopback_rx();
    logic [7:0] d;
    logic       rose;
    loopEn = 1'b1;
    busWrite(3'd2, 8'h01);
    busWrite(3'd0, 8'hA3);
    rose = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      waitCycles(1);
      if (rx_irq == 1'b1) begin
        rose = 1'b1;
        break;
      end
    end
    checks++;
    if (!rose) begin
      failures++;
      $display("[TB] FAIL loop_rx_irq_rise: got rx_irq=%b expected 1", rx_irq);
    end
    busRead(3'd0, d);
    checks++;
    if (d !== 8'hA3) begin
      failures++;
      $display("[TB] FAIL loop_rx_data: got %h expected a3", d);
    end
    waitCycles(2);
    checks++;
    if (rx_irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL loop_rx_irq_fall: got %b expected 0", rx_irq);
    end
    busWrite(3'd2, 8'h00);
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] bytesOut [5];
    logic       idle;
    bytesOut = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) busWrite(3'd0, bytesOut[i]);
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      waitCycles(100);
      busRead(3'd1, d);
      if (d[3]) begin
        idle = 1'b1;
        break;
      end
    end
    checks++;
    if (!idle) begin
      failures++;
      $display("[TB] FAIL ovr_tx_drain: got status %h expected tx_idle set", d);
    end
    waitCycles(20);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0F) begin
      failures++;
      $display("[TB] FAIL ovr_status: got %h expected 0f", d);
    end
    for (int i = 0; i < 4; i++) begin
      busRead(3'd0, d);
      checks++;
      if (d !== bytesOut[i]) begin
        failures++;
        $display("[TB] FAIL ovr_data%0d: got %h expected %h", i, d, bytesOut[i]);
      end
    end
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0E) begin
      failures++;
      $display("[TB] FAIL ovr_after_drain: got %h expected 0e", d);
    end
    busWrite(3'd1, 8'h00);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL ovr_clear: got %h expected 0a", d);
    end
    loopEn = 1'b0;
  endtask

  task automatic test_glitch_framing();
    logic [7:0] d;
    rxdDrv = 1'b1;
    setDivisor(16'h0000);
    rxdDrv = 1'b0;
    waitCycles(4);
    rxdDrv = 1'b1;
    waitCycles(40);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL glitch_status: got %h expected 0a", d);
    end
    sendSerial(8'h96, 1'b1);
    waitCycles(10);
    busRead(3'd0, d);
    checks++;
    if (d !== 8'h96) begin
      failures++;
      $display("[TB] FAIL glitch_recover_data: got %h expected 96", d);
    end
    sendSerial(8'h3C, 1'b0);
    waitCycles(40);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h1A) begin
      failures++;
      $display("[TB] FAIL framing_status: got %h expected 1a", d);
    end
    busRead(3'd0, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL framing_empty: got %h expected 00", d);
    end
  endtask

  task automatic test_cts_reset();
    logic [7:0] d;
    logic       fell;
    int         lowCnt;
    setDivisor(16'h0001);
    cts = 1'b0;
    waitCycles(4);
    busWrite(3'd1, 8'h00);
    busWrite(3'd0, 8'h41);
    lowCnt = 0;
    for (int i = 0; i < 100; i++) begin
      waitCycles(1);
      if (txd == 1'b0) lowCnt++;
    end
    checks++;
    if (lowCnt != 0) begin
      failures++;
      $display("[TB] FAIL cts_hold_txd: got %0d low clk expected 0", lowCnt);
    end
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("[TB] FAIL cts_hold_status: got %h expected 02", d);
    end
    cts = 1'b1;
    fell = 1'b0;
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      if (txd == 1'b0) begin
        fell = 1'b1;
        break;
      end
    end
    checks++;
    if (!fell) begin
      failures++;
      $display("[TB] FAIL cts_release_start: got no start bit expected txd low within 50 clk");
    end
    waitCycles(100);
    nRST = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_midchar_txd: got %b expected 1", txd);
    end
    waitCycles(2);
    nRST = 1'b1;
    waitCycles(3);
    busRead(3'd1, d);
    checks++;
    if (d !== 8'h0A) begin
      failures++;
      $display("[TB] FAIL reset_midchar_status: got %h expected 0a", d);
    end
    busRead(3'd3, d);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_midchar_div: got %h expected 00", d);
    end
  endtask

  initial begin
    test_reset();
    test_control();
    test_tx_waveform();
    test_loopback_rx();
    test_overrun();
    test_glitch_framing();
    test_cts_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
